// File: rtl/bcd_conv_arbiter.sv
// Round-robin sequencer sharing one bin2BCD converter among N_REQ requesters.
// One conversion in flight at a time; a hung converter is aborted after TIMEOUT cycles.
module bcd_conv_arbiter #(
  parameter int N_REQ   = 2,
  parameter int BIN_W   = 12,
  parameter int BCD_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*BIN_W-1:0] bin_in,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic [BCD_W-1:0]       bcd_out,
  output logic                   conv_en,
  output logic [BIN_W-1:0]       conv_bin,
  input  logic [BCD_W-1:0]       conv_bcd,
  input  logic                   conv_rdy,
  output logic                   busy,
  output logic                   timeout_err
);
  localparam int PW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [PW-1:0]      ptr_q, ptr_d, win;
  logic               any_req;
  logic [BIN_W-1:0]   conv_bin_q, conv_bin_d;
  logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
  logic               rdy_q, rdy_d, rdy_edge, tmo_hit;
  logic [TW-1:0]      timer_q, timer_d;
  logic               timeout_err_q, timeout_err_d;
  logic [BIN_W-1:0]   bin_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign bin_arr[g] = bin_in[g*BIN_W +: BIN_W];
  end

  // Scan from ptr+1 with wrap so the last winner has lowest priority.
  always_comb begin : arb
    logic [PW:0] cand;
    cand    = '0;
    win     = ptr_q;
    any_req = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand >= (PW+1)'(N_REQ)) cand = cand - (PW+1)'(N_REQ);
      if (!any_req && req[cand[PW-1:0]]) begin
        any_req = 1'b1;
        win     = cand[PW-1:0];
      end
    end
  end

  // rdy_q tracks conv_rdy every cycle, so a level already high at ISSUE is no edge.
  assign rdy_edge = conv_rdy & ~rdy_q;
  assign tmo_hit  = (timer_q == TW'(TIMEOUT-1));

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (rdy_edge || tmo_hit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : datapath
    grant_d       = grant_q;
    ptr_d         = ptr_q;
    conv_bin_d    = conv_bin_q;
    bcd_out_d     = bcd_out_q;
    rdy_d         = conv_rdy;
    timer_d       = timer_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      S_IDLE: if (any_req) begin
        grant_d      = '0;
        grant_d[win] = 1'b1;
        ptr_d        = win;
        conv_bin_d   = bin_arr[win];
      end
      S_ISSUE: timer_d = '0;
      S_WAIT: begin
        if (rdy_edge)     bcd_out_d     = conv_bcd;
        else if (tmo_hit) timeout_err_d = 1'b1;
        else              timer_d       = timer_q + TW'(1);
      end
      S_DONE:  grant_d = '0;
      default: grant_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      ptr_q         <= PW'(N_REQ-1);
      conv_bin_q    <= '0;
      bcd_out_q     <= '0;
      rdy_q         <= 1'b1;
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      ptr_q         <= ptr_d;
      conv_bin_q    <= conv_bin_d;
      bcd_out_q     <= bcd_out_d;
      rdy_q         <= rdy_d;
      timer_q       <= timer_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin : outputs
    conv_en = (state_q == S_ISSUE);
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE) ? grant_q : '0;
  end

  assign grant       = grant_q;
  assign bcd_out     = bcd_out_q;
  assign conv_bin    = conv_bin_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Bench for bcd_conv_arbiter: behavioural converter, scoreboard monitor,
// a vector table, and hand sequences for held rdy, timeout, reset and late bin_in.
module tb_bcd_conv_arbiter;
  localparam int N  = 2;
  localparam int BW = 12;
  localparam int CW = 16;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*BW-1:0] bin_in;
  logic [N-1:0]  grant, done;
  logic [CW-1:0] bcd_out, conv_bcd;
  logic          conv_en, conv_rdy, busy, timeout_err;
  logic [BW-1:0] conv_bin;

  bcd_conv_arbiter #(.N_REQ(N), .BIN_W(BW), .BCD_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .bin_in(bin_in), .grant(grant), .done(done),
    .bcd_out(bcd_out), .conv_en(conv_en), .conv_bin(conv_bin), .conv_bcd(conv_bcd),
    .conv_rdy(conv_rdy), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [CW-1:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Converter model: rdy drops cv_drop negedges after en, rises cv_dly after en.
  int cv_dly = 20, cv_drop = 0, cv_age = 0, cv_val = 0, rise_cyc = -100;
  bit cv_hang = 0, cv_act = 0;
  initial begin
    conv_rdy = 1'b1;
    conv_bcd = '0;
    forever begin
      @(negedge clk);
      if (conv_en) begin
        cv_act = 1; cv_age = 0; cv_val = int'(conv_bin);
      end else if (cv_act) cv_age++;
      if (cv_act) begin
        if (cv_age == cv_drop) begin conv_rdy = 1'b0; conv_bcd = 16'hEEEE; end
        if (!cv_hang && cv_age == cv_dly) begin
          conv_rdy = 1'b1; conv_bcd = to_bcd(cv_val); rise_cyc = cyc; cv_act = 0;
        end
      end
    end
  end

  typedef struct {int who; logic [BW-1:0] bin; logic [CW-1:0] bcd; bit hang;} exp_t;
  exp_t q[$];
  exp_t e;
  bit own = 0, mterr = 0;
  int mptr = N - 1, mw = 0, en_cyc = 0;
  logic [CW-1:0] mbcd = '0;

  // Scoreboard monitor, sampled 1 time unit after each rising edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (conv_en) begin
      chk("en_while_owned", 32'(own), 0);
      chk("en_with_req", 32'(req != 0), 1);
      mw = -1;
      for (int k = 1; k <= N; k++)
        if (mw < 0 && req[(mptr + k) % N]) mw = (mptr + k) % N;
      if (mw >= 0) begin
        e.who = mw; e.bin = bin_in[mw*BW +: BW]; e.hang = cv_hang;
        e.bcd = cv_hang ? mbcd : to_bcd(int'(e.bin));
        q.push_back(e); mptr = mw; own = 1; en_cyc = cyc;
      end
    end
    if (own) begin
      chk("grant_owner", 32'(grant), 32'(1) << q[0].who);
      chk("conv_bin_stable", 32'(conv_bin), 32'(q[0].bin));
    end else chk("grant_idle", 32'(grant), 0);
    chk("busy", 32'(busy), 32'(own));
    if (|done) begin
      if (q.size() == 0) chk("unexpected_done", 32'(done), 0);
      else begin
        e = q.pop_front();
        chk("done_owner", 32'(done), 32'(1) << e.who);
        if (e.hang) begin
          chk("timeout_at_done", 32'(timeout_err), 1);
          chk("timeout_latency", 32'((cyc - en_cyc) >= TO + 1 && (cyc - en_cyc) <= TO + 2), 1);
          mterr = 1;
        end else chk("done_latency", 32'(cyc), 32'(rise_cyc + 1));
        mbcd = e.bcd;
        own  = 0;
      end
    end
    chk("bcd_out", 32'(bcd_out), 32'(mbcd));
    if (!own || !q[0].hang) chk("timeout_err", 32'(timeout_err), 32'(mterr));
  end

  task automatic wait_done(output logic [N-1:0] d, input int lim);
    d = '0;
    for (int n = 0; n < lim; n++) begin
      @(posedge clk); #1;
      if (|done) begin d = done; return; end
    end
    total++; bad++;
    $display("FAIL wait_done: no done within %0d cycles (cycle %0d)", lim, cyc);
  endtask

  task automatic wait_en(input int lim);
    for (int n = 0; n < lim; n++) begin
      @(posedge clk); #1;
      if (conv_en) return;
    end
    total++; bad++;
    $display("FAIL wait_en: no conv_en within %0d cycles (cycle %0d)", lim, cyc);
  endtask

  task automatic release_req();
    @(negedge clk); req = '0;
    @(posedge clk); #1;
    chk("idle_after_done", 32'(busy), 0);
  endtask

  typedef struct {logic [N-1:0] rq; int b0; int b1; int dly; logic [N-1:0] g; logic [CW-1:0] bcd;} vec_t;
  vec_t tbl[7];
  logic [N-1:0] d;
  int rst_cyc;

  initial begin
    // Pointer starts at N-1, so a tie goes to requester 0 first.
    tbl[0] = '{2'b01, 1234,    0, 20, 2'b01, 16'h1234};
    tbl[1] = '{2'b10,    0, 4095, 20, 2'b10, 16'h4095};
    tbl[2] = '{2'b11,    5,    7,  9, 2'b01, 16'h0005};
    tbl[3] = '{2'b11,    0,  999,  9, 2'b10, 16'h0999};
    tbl[4] = '{2'b11, 4000,    1,  3, 2'b01, 16'h4000};
    tbl[5] = '{2'b01,    0,    0,  3, 2'b01, 16'h0000};
    tbl[6] = '{2'b10,    0,   10,  1, 2'b10, 16'h0010};

    rst = 1'b1; req = '0; bin_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_en_busy", 32'({conv_en, busy, timeout_err}), 0);
    chk("rst_bcd", 32'(bcd_out), 0);
    chk("rst_conv_bin", 32'(conv_bin), 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      cv_dly = tbl[i].dly;
      bin_in = {BW'(tbl[i].b1), BW'(tbl[i].b0)};
      req    = tbl[i].rq;
      wait_done(d, 100);
      chk("tbl_done", 32'(d), 32'(tbl[i].g));
      chk("tbl_bcd", 32'(bcd_out), 32'(tbl[i].bcd));
      release_req();
    end

    // Both requesters held: service alternates, starting with 0 (pointer is 1).
    @(negedge clk); cv_dly = 6; bin_in = {12'd4095, 12'd5}; req = 2'b11;
    for (int i = 0; i < 6; i++) begin
      wait_done(d, 100);
      chk("alt_grant", 32'(d), (i % 2 == 0) ? 32'h1 : 32'h2);
      chk("alt_bcd", 32'(bcd_out), (i % 2 == 0) ? 32'h0005 : 32'h4095);
    end
    release_req();

    // rdy already high at ISSUE; only the later rising edge completes.
    @(negedge clk); cv_drop = 5; cv_dly = 10; bin_in = {12'd0, 12'd42}; req = 2'b01;
    wait_done(d, 100);
    chk("held_rdy_latency", 32'(cyc - en_cyc), 11);
    chk("held_rdy_bcd", 32'(bcd_out), 32'h0042);
    release_req();
    cv_drop = 0;

    // Hung converter: abort, result unchanged, error sticks, service continues.
    @(negedge clk); cv_hang = 1; bin_in = {12'd0, 12'd321}; req = 2'b01;
    wait_done(d, TO + 10);
    chk("to_done", 32'(d), 1);
    chk("to_err", 32'(timeout_err), 1);
    chk("to_bcd_kept", 32'(bcd_out), 32'h0042);
    release_req();
    @(negedge clk); cv_hang = 0; cv_dly = 8; bin_in = {12'd77, 12'd0}; req = 2'b10;
    wait_done(d, 100);
    chk("post_to_done", 32'(d), 2);
    chk("post_to_bcd", 32'(bcd_out), 32'h0077);
    chk("post_to_err_sticky", 32'(timeout_err), 1);
    release_req();

    // Reset mid-WAIT; the converter's late rdy edge must not produce a done.
    @(negedge clk); cv_dly = 20; bin_in = {12'd0, 12'd111}; req = 2'b01;
    wait_en(20);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; req = '0;
    q.delete(); own = 0; mptr = N - 1; mbcd = '0; mterr = 0;
    rst_cyc = cyc;
    @(negedge clk); rst = 1'b0;
    chk("mid_rst_grant", 32'(grant), 0);
    chk("mid_rst_flags", 32'({done, conv_en, busy, timeout_err}), 0);
    chk("mid_rst_bcd", 32'(bcd_out), 0);
    chk("mid_rst_conv_bin", 32'(conv_bin), 0);
    repeat (30) @(posedge clk);
    #1;
    chk("stale_rdy_seen", 32'(rise_cyc > rst_cyc), 1);
    chk("stale_no_busy", 32'(busy), 0);
    @(negedge clk); cv_dly = 5; bin_in = {12'd3, 12'd2048}; req = 2'b11;
    wait_done(d, 100);
    chk("post_rst_ptr", 32'(d), 1);
    chk("post_rst_bcd", 32'(bcd_out), 32'h2048);
    release_req();

    // bin_in changes after the latch; the latched operand is converted.
    @(negedge clk); cv_dly = 20; bin_in = {12'd0, 12'd1500}; req = 2'b01;
    wait_en(20);
    repeat (2) @(posedge clk);
    @(negedge clk); bin_in = {12'd0, 12'd2222};
    wait_done(d, 100);
    chk("late_bin_done", 32'(d), 1);
    chk("late_bin_bcd", 32'(bcd_out), 32'h1500);
    release_req();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
